// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op at a time to the ALU, holds operands, acks the result and returns it with the predicate outcome.
// Define ALU_TIMEOUT_EN to add the err port and a MAX_WAIT cycle result timeout.
module alu_issue_ctrl #(
  parameter int TAG_W = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_cond,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  output logic             alu_en,
  input  logic [31:0]      alu_out,
  input  logic             alu_set,
  input  logic             alu_eq,
  input  logic             alu_gt,
  input  logic             alu_ge,
  input  logic             alu_vld,
  output logic             alu_ack,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [31:0]      out_res,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag,
`ifdef ALU_TIMEOUT_EN
  output logic             err,
`endif
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [2:0] cond;
  logic       taken_c;
  logic       timeout;
  assign in_rdy  = state == IDLE;
  assign alu_en  = state == ISSUE;
  assign out_vld = state == RESP;
  assign busy    = state != IDLE;
  always_comb
    taken_c = cond == 3'd1 ? alu_eq  :
              cond == 3'd2 ? alu_gt  :
              cond == 3'd3 ? alu_ge  :
              cond == 3'd4 ? alu_set : 1'b0;
`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  // a result that shows up after a timeout is swallowed while idle
  assign alu_ack = alu_vld && (state == WAIT || state == IDLE);
  assign timeout = state == WAIT && !alu_vld && cnt == CW'(MAX_WAIT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      err <= timeout ? 1'b1 : (state == RESP && out_rdy) ? 1'b0 : err;
    end
`else
  assign alu_ack = alu_vld && state == WAIT;
  assign timeout = 1'b0;
  if (MAX_WAIT < 1) begin : g_bad_wait
    $error("MAX_WAIT must be positive");
  end
`endif
  // operand registers only load on acceptance, so they stay stable for the whole op
  always_ff @(posedge clk)
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cond      <= '0;
      out_tag   <= '0;
      out_res   <= '0;
      out_taken <= 1'b0;
    end else begin
      if (state == IDLE && in_vld) begin
        state   <= ISSUE;
        alu_a   <= in_a;
        alu_b   <= in_b;
        alu_sel <= in_op;
        cond    <= in_cond;
        out_tag <= in_tag;
      end
      if (state == ISSUE) state <= WAIT;
      if (state == WAIT && alu_vld) begin
        state     <= RESP;
        out_res   <= alu_out;
        out_taken <= taken_c;
      end
      if (timeout) begin
        state     <= RESP;
        out_res   <= 32'hDEADBEEF;
        out_taken <= 1'b0;
      end
      if (state == RESP && out_rdy) state <= IDLE;
    end
endmodule
